int_ctrl: RTL and testbench
===========================

# int_ctrl

Parametrised vectored interrupt controller for the msp430 core, the next-generation replacement for the fixed two-input interrupt block. It accepts `N_SRC` interrupt sources (external IRQ pins and timer IRT outputs), each individually enabled and configured as level- or edge-triggered. It arbitrates by fixed priority, gated by the GIE bit of the CPU status register, and hands one vector address at a time to the program sequencer over a REQ/ACK/RTI handshake.

## Interface
- `N_SRC`, 4: number of interrupt sources, 2..16; index 0 has the highest priority.
- `VEC_BASE`, 16'hFFE0: program-memory address of the vector for source 0.
- `GIE_BIT`, 3: bit position of GIE in `SR`.
- `CLK`, in, 1: system clock (F1 domain); all state updates on the rising edge.
- `RESET`, in, 1: asynchronous reset, active-high.
- `IRQ`, in, N_SRC: raw interrupt sources; asynchronous to `CLK`.
- `IE`, in, N_SRC: per-source enable mask.
- `EDGE`, in, N_SRC: per-source mode; 1 = rising-edge, 0 = level.
- `SR`, in, 16: CPU status register; only bit `GIE_BIT` is used.
- `ACK`, in, 1: one-cycle pulse from the sequencer; the vector has been taken.
- `RTI`, in, 1: one-cycle pulse from the sequencer; return-from-interrupt executed.
- `REQ`, out, 1: interrupt request to the sequencer.
- `ADDR_INT`, out, 16: vector address; valid while `REQ`=1.
- `ACTIVE_ID`, out, 4: index of the requested or in-service source.
- `IN_SERVICE`, out, 1: a handler is currently executing.
- `PENDING`, out, N_SRC: pending flags, before masking by `IE`.

## Operation
- **Synchronizer:** each `IRQ` bit passes through two flops (s1, s2). A third flop (s3) provides edge detection.
- **Pending, edge mode:**
  - Set when s2 & ~s3.
  - Cleared when `ACK` is accepted for that source.
  - If a set and a clear occur in the same cycle, set wins.
- **Pending, level mode:** the register loads s2 every cycle. `ACK` has no effect on it.
- **Eligible:** `PENDING & IE`. The winner is the lowest eligible index.
- **State machine (IDLE, REQUEST, SERVICE):**
  - IDLE -> REQUEST when any source is eligible and `SR[GIE_BIT]`=1. On entry, latch the winner into `ACTIVE_ID` and `ADDR_INT` = `VEC_BASE` + 2*winner, computed modulo 2^16.
  - REQUEST: `REQ`=1. `ACTIVE_ID` and `ADDR_INT` stay frozen; a higher-priority arrival does not re-vector.
    - On `ACK`: go to SERVICE and clear the edge pending flag of `ACTIVE_ID`.
    - On `SR[GIE_BIT]`=0 without `ACK`: withdraw and return to IDLE. If `ACK` and a GIE drop occur in the same cycle, `ACK` wins.
  - SERVICE: `REQ`=0, `IN_SERVICE`=1. No nesting. On `RTI`, go to IDLE; the next arbitration can occur the following cycle.
- **Ignored inputs:**
  - `ACK` in IDLE or SERVICE.
  - `RTI` in IDLE or REQUEST.
- A disabled source (`IE`=0) keeps its edge pending flag. It becomes eligible again when `IE` is set.

## Timing
- **Reset values:**
  - `REQ`=0, `IN_SERVICE`=0, `ACTIVE_ID`=0.
  - `ADDR_INT`=`VEC_BASE`.
  - `PENDING`=0, all synchronizer flops 0, state IDLE.
  - Reset mid-operation discards all pending and in-service state immediately, without waiting for a clock.
- **Latency:** `IRQ` rises before edge k → s1 at k, s2 at k+1, `PENDING` at k+2, `REQ`=1 after edge k+3. Level and edge modes have the same latency.
- **Gate timing:** `SR[GIE_BIT]` and `IE` are sampled at the edge that would enter REQUEST.
- **`ACK` response:** `ACK` sampled at edge m → `REQ`=0 and `IN_SERVICE`=1 after m. The edge pending flag is cleared after m.
- **`RTI` response:** `RTI` at edge r → IDLE after r. If eligible work exists, `REQ`=1 after r+1.
- **Level source held high through `RTI`:** it re-requests per the `RTI` response timing above.
- **Minimum edge spacing:** an edge pulse must be high for at least 2 `CLK` cycles to be captured reliably.
- **Output registration:** all outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** hold `RESET`=1 with `IRQ`=all ones → `REQ`=0, `ADDR_INT`=16'hFFE0, `PENDING`=0. After release, with `IE`=4'hF and GIE=1, `REQ`=1 after 4 edges.
- **Priority:** `EDGE`=4'hF; pulse `IRQ[2]` and `IRQ[1]` together → `ADDR_INT`=16'hFFE2, `ACTIVE_ID`=1. `ACK` then `RTI` → next request `ADDR_INT`=16'hFFE4.
- **GIE gating:** pending `IRQ[0]` with `SR[3]`=0 → `REQ` stays 0 for 20 cycles. Set `SR[3]`=1 → `REQ`=1 the next cycle. Clear GIE while in REQUEST → `REQ`=0 next cycle and `PENDING[0]` is still 1.
- **Edge vs level:** `EDGE[3]`=0 with `IRQ[3]` held high. `ACK`, then `RTI` → `REQ`=1 again with `ADDR_INT`=16'hFFE6. The same sequence with `EDGE[3]`=1 → no second request.
- **Simultaneous set/clear:** new edge on `IRQ[0]` landing in `PENDING` on the `ACK` cycle → `PENDING[0]` stays 1. After `RTI` the source is re-requested.
- **Masking and reset mid-service:** `IE[1]`=0 with an edge on `IRQ[1]` → `PENDING[1]`=1 and no `REQ`. Set `IE[1]` → request with `ADDR_INT`=16'hFFE2. Assert `RESET` in SERVICE → `IN_SERVICE`=0 asynchronously.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: vectored interrupt controller for the msp430 core.
// Takes N_SRC interrupt sources (level or rising-edge, each individually
// enabled), picks the lowest eligible index when GIE is set, and presents
// one vector at a time to the sequencer over a REQ/ACK/RTI handshake.
module int_ctrl #(
  parameter int          N_SRC    = 4,
  parameter logic [15:0] VEC_BASE = 16'hFFE0,
  parameter int          GIE_BIT  = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [N_SRC-1:0]  IRQ,
  input  logic [N_SRC-1:0]  IE,
  input  logic [N_SRC-1:0]  EDGE,
  input  logic [15:0]       SR,
  input  logic              ACK,
  input  logic              RTI,
  output logic              REQ,
  output logic [15:0]       ADDR_INT,
  output logic [3:0]        ACTIVE_ID,
  output logic              IN_SERVICE,
  output logic [N_SRC-1:0]  PENDING
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQUEST = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [N_SRC-1:0] syncS1_q;
  logic [N_SRC-1:0] syncS2_q;
  logic [N_SRC-1:0] syncS3_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] pending_d;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [3:0]       activeId_q;
  logic [3:0]       activeId_d;
  logic [15:0]      addrInt_q;
  logic [15:0]      addrInt_d;

  logic [N_SRC-1:0] risingEdge;
  logic [N_SRC-1:0] ackClear;
  logic [N_SRC-1:0] eligible;
  logic [3:0]       winnerId;
  logic [15:0]      winnerAddr;
  logic             gieOn;
  logic             unusedSr;

  // Only the GIE bit of the status register matters; the rest is folded away.
  assign gieOn    = SR[GIE_BIT];
  assign unusedSr = ^SR;

  // Two-flop synchronizer for the asynchronous IRQ pins, plus a third stage
  // holding the previous synchronized value for rising-edge detection.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      syncS1_q <= '0;
      syncS2_q <= '0;
      syncS3_q <= '0;
    end else begin
      syncS1_q <= IRQ;
      syncS2_q <= syncS1_q;
      syncS3_q <= syncS2_q;
    end
  end

  assign risingEdge = syncS2_q & ~syncS3_q;
  assign ackClear   = (state_q == ST_REQUEST && ACK)
                      ? ({{(N_SRC-1){1'b0}}, 1'b1} << activeId_q)
                      : '0;

  // Edge sources latch a rise and hold it until their vector is taken (a
  // fresh rise in the ACK cycle wins); level sources simply follow the pin.
  always_comb begin
    pending_d = (EDGE & (risingEdge | (pending_q & ~ackClear)))
              | (~EDGE & syncS2_q);
  end

  // Pending flags are kept regardless of IE so masked sources are not lost.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign eligible = pending_q & IE;

  // Fixed priority: scanning downwards leaves the lowest eligible index.
  always_comb begin
    winnerId = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winnerId = 4'(i);
      end
    end
  end

  assign winnerAddr = VEC_BASE + {11'd0, winnerId, 1'b0};

  // Handshake sequencing: the vector is frozen once requested, ACK beats a
  // simultaneous GIE drop, and nothing nests while a handler is running.
  always_comb begin
    state_d    = state_q;
    activeId_d = activeId_q;
    addrInt_d  = addrInt_q;
    case (state_q)
      ST_IDLE: begin
        if (|eligible && gieOn) begin
          state_d    = ST_REQUEST;
          activeId_d = winnerId;
          addrInt_d  = winnerAddr;
        end
      end
      ST_REQUEST: begin
        if (ACK) begin
          state_d = ST_SERVICE;
        end else if (!gieOn) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (RTI) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched vector registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      activeId_q <= '0;
      addrInt_q  <= VEC_BASE;
    end else begin
      state_q    <= state_d;
      activeId_q <= activeId_d;
      addrInt_q  <= addrInt_d;
    end
  end

  assign REQ        = (state_q == ST_REQUEST);
  assign IN_SERVICE = (state_q == ST_SERVICE);
  assign ACTIVE_ID  = activeId_q;
  assign ADDR_INT   = addrInt_q;
  assign PENDING    = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: self-checking bench for int_ctrl. A behavioural model driven
// by the IRQ history predicts the outputs after every clock edge; those
// predictions are queued and a separate monitor compares them to the DUT.
module tb_int_ctrl;

  logic        CLK;
  logic        RESET;
  logic [3:0]  IRQ;
  logic [3:0]  IE;
  logic [3:0]  EDGE;
  logic [15:0] SR;
  logic        ACK;
  logic        RTI;
  logic        REQ;
  logic [15:0] ADDR_INT;
  logic [3:0]  ACTIVE_ID;
  logic        IN_SERVICE;
  logic [3:0]  PENDING;

  typedef struct {
    logic        req;
    logic        svc;
    logic [3:0]  pend;
    logic [3:0]  id;
    logic [15:0] addr;
  } expect_t;

  expect_t    sbQ[$];
  logic [3:0] irqHist[$];

  logic [3:0]  mPend;
  logic        mRequesting;
  logic        mServicing;
  int          mId;
  logic [15:0] mAddr;

  logic [3:0]  irqV;
  logic [3:0]  ieV;
  logic [3:0]  edgeV;
  logic [15:0] srV;

  int checkCount = 0;
  int errorCount = 0;

  int_ctrl #(.N_SRC(4), .VEC_BASE(16'hFFE0), .GIE_BIT(3)) dut (
    .CLK(CLK), .RESET(RESET), .IRQ(IRQ), .IE(IE), .EDGE(EDGE), .SR(SR),
    .ACK(ACK), .RTI(RTI), .REQ(REQ), .ADDR_INT(ADDR_INT),
    .ACTIVE_ID(ACTIVE_ID), .IN_SERVICE(IN_SERVICE), .PENDING(PENDING)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h",
               name, $time, actual, expected);
    end
  endtask

  task automatic modelReset();
    irqHist.delete();
    for (int i = 0; i < 3; i++) irqHist.push_back(4'h0);
    mPend       = 4'h0;
    mRequesting = 1'b0;
    mServicing  = 1'b0;
    mId         = 0;
    mAddr       = 16'hFFE0;
  endtask

  // One clock edge of the reference: pending follows the pin value seen two
  // edges earlier (level) or its rise (edge); then the handshake rules apply.
  task automatic modelStep(input logic ack, input logic rti);
    logic [3:0] level;
    logic [3:0] rose;
    logic [3:0] elig;
    logic [3:0] newPend;
    logic       gie;
    bit         found;
    int         win;
    expect_t    e;
    irqHist.push_front(irqV);
    level = irqHist[2];
    rose  = irqHist[2] & ~irqHist[3];
    void'(irqHist.pop_back());
    elig = mPend & ieV;
    gie  = srV[3];
    for (int i = 0; i < 4; i++) begin
      if (edgeV[i])
        newPend[i] = rose[i] | (mPend[i] & !(mRequesting && ack && mId == i));
      else
        newPend[i] = level[i];
    end
    if (mRequesting) begin
      if (ack) begin
        mRequesting = 1'b0;
        mServicing  = 1'b1;
      end else if (!gie) begin
        mRequesting = 1'b0;
      end
    end else if (mServicing) begin
      if (rti) mServicing = 1'b0;
    end else if (elig != 4'h0 && gie) begin
      found = 0;
      win   = 0;
      for (int i = 0; i < 4; i++) begin
        if (elig[i] && !found) begin
          found = 1;
          win   = i;
        end
      end
      mId         = win;
      mAddr       = 16'((32'hFFE0 + 2 * win) % 65536);
      mRequesting = 1'b1;
    end
    mPend  = newPend;
    e.req  = mRequesting;
    e.svc  = mServicing;
    e.pend = mPend;
    e.id   = 4'(mId);
    e.addr = mAddr;
    sbQ.push_back(e);
  endtask

  // Drive one cycle of inputs, predict the result, then wait past the edge.
  task automatic applyStimulus(input logic ack, input logic rti);
    IRQ  = irqV;
    IE   = ieV;
    EDGE = edgeV;
    SR   = srV;
    ACK  = ack;
    RTI  = rti;
    modelStep(ack, rti);
    @(posedge CLK);
    #2;
  endtask

  task automatic runIdle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0);
  endtask

  // Monitor: after every edge, compare the DUT with the oldest prediction.
  always @(posedge CLK) begin : monitor
    expect_t e;
    #1;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput("req", 32'(REQ), 32'(e.req));
      checkOutput("inService", 32'(IN_SERVICE), 32'(e.svc));
      checkOutput("pending", 32'(PENDING), 32'(e.pend));
      if (e.req) checkOutput("addrInt", 32'(ADDR_INT), 32'(e.addr));
      if (e.req || e.svc) checkOutput("activeId", 32'(ACTIVE_ID), 32'(e.id));
    end
  end

  initial begin
    RESET = 1'b1;
    irqV = 4'hF; ieV = 4'hF; edgeV = 4'h0; srV = 16'h0008;
    IRQ = irqV; IE = ieV; EDGE = edgeV; SR = srV; ACK = 1'b0; RTI = 1'b0;
    modelReset();

    // Reset held with all IRQ high.
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rstReq", 32'(REQ), 32'd0);
    checkOutput("rstAddr", 32'(ADDR_INT), 32'hFFE0);
    checkOutput("rstPending", 32'(PENDING), 32'd0);
    checkOutput("rstInService", 32'(IN_SERVICE), 32'd0);
    checkOutput("rstActiveId", 32'(ACTIVE_ID), 32'd0);
    #1;
    RESET = 1'b0;
    modelReset();
    runIdle(3);
    checkOutput("latencyNoReqYet", 32'(REQ), 32'd0);
    runIdle(1);
    checkOutput("latencyReq", 32'(REQ), 32'd1);

    // Priority between two simultaneous edge sources.
    irqV = 4'h0;
    applyStimulus(1'b1, 1'b0);
    runIdle(3);
    applyStimulus(1'b0, 1'b1);
    runIdle(2);
    edgeV = 4'hF;
    irqV = 4'b0110;
    runIdle(2);
    irqV = 4'h0;
    runIdle(3);
    checkOutput("prioAddr", 32'(ADDR_INT), 32'hFFE2);
    checkOutput("prioId", 32'(ACTIVE_ID), 32'd1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    runIdle(1);
    checkOutput("prioNextReq", 32'(REQ), 32'd1);
    checkOutput("prioNextAddr", 32'(ADDR_INT), 32'hFFE4);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);

    // GIE gating and withdrawal.
    srV = 16'h0000;
    irqV = 4'b0001;
    runIdle(2);
    irqV = 4'h0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("gieBlocked", 32'(REQ), 32'd0);
    end
    srV = 16'h0008;
    runIdle(1);
    checkOutput("gieReq", 32'(REQ), 32'd1);
    srV = 16'h0000;
    runIdle(1);
    checkOutput("gieWithdraw", 32'(REQ), 32'd0);
    checkOutput("gieKeepsPending", 32'(PENDING[0]), 32'd1);
    srV = 16'h0008;
    runIdle(1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);

    // Level source held through RTI re-requests; edge source does not.
    edgeV = 4'b0111;
    irqV = 4'b1000;
    runIdle(4);
    checkOutput("levelAddr", 32'(ADDR_INT), 32'hFFE6);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    runIdle(1);
    checkOutput("levelReReq", 32'(REQ), 32'd1);
    checkOutput("levelReAddr", 32'(ADDR_INT), 32'hFFE6);
    irqV = 4'h0;
    applyStimulus(1'b1, 1'b0);
    runIdle(3);
    applyStimulus(1'b0, 1'b1);
    runIdle(4);
    edgeV = 4'hF;
    irqV = 4'b1000;
    runIdle(4);
    checkOutput("edgeAddr", 32'(ADDR_INT), 32'hFFE6);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    runIdle(5);
    checkOutput("edgeNoReReq", 32'(REQ), 32'd0);
    irqV = 4'h0;
    runIdle(3);

    // New edge landing in PENDING on the ACK cycle survives the clear.
    irqV = 4'b0001;
    runIdle(2);
    irqV = 4'h0;
    runIdle(2);
    irqV = 4'b0001;
    runIdle(2);
    applyStimulus(1'b1, 1'b0);
    checkOutput("setWinsPending", 32'(PENDING[0]), 32'd1);
    irqV = 4'h0;
    applyStimulus(1'b0, 1'b1);
    runIdle(1);
    checkOutput("setWinsReReq", 32'(REQ), 32'd1);
    checkOutput("setWinsAddr", 32'(ADDR_INT), 32'hFFE0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);

    // Masked source keeps its flag; asynchronous reset mid-service.
    ieV = 4'b1101;
    irqV = 4'b0010;
    runIdle(2);
    irqV = 4'h0;
    runIdle(4);
    checkOutput("maskedPending", 32'(PENDING[1]), 32'd1);
    checkOutput("maskedNoReq", 32'(REQ), 32'd0);
    ieV = 4'hF;
    runIdle(1);
    checkOutput("unmaskReq", 32'(REQ), 32'd1);
    checkOutput("unmaskAddr", 32'(ADDR_INT), 32'hFFE2);
    applyStimulus(1'b1, 1'b0);
    checkOutput("preResetSvc", 32'(IN_SERVICE), 32'd1);
    #1;
    RESET = 1'b1;
    #1;
    checkOutput("asyncRstSvc", 32'(IN_SERVICE), 32'd0);
    checkOutput("asyncRstReq", 32'(REQ), 32'd0);
    checkOutput("asyncRstAddr", 32'(ADDR_INT), 32'hFFE0);
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    modelReset();

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      logic ack;
      logic rti;
      if ($urandom_range(0, 3) == 0) irqV = irqV ^ 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) ieV = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) edgeV = 4'($urandom_range(0, 15));
      srV = 16'($urandom);
      srV[3] = ($urandom_range(0, 99) < 85);
      ack = mRequesting ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      rti = mServicing ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      applyStimulus(ack, rti);
    end

    ACK = 1'b0;
    RTI = 1'b0;
    @(posedge CLK);
    #2;
    checkOutput("scoreboardDrained", 32'(sbQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
